// File: rtl/ptw_trk_pkg.sv
// Shared types and widths for the page-table-walk transaction tracker.
// The record layout below is the exact bit order presented on rec_data.
package ptw_trk_pkg;

   localparam int VPN_W = 27;
   localparam int PPN_W = 20;
   localparam int FLG_W = 8;
   localparam int LAT_W = 16;
   localparam int REC_W = 74;

   typedef enum logic {IDLE, WAIT} state_e;

   typedef struct packed {
      logic [VPN_W-1:0] vpn;
      logic [PPN_W-1:0] ppn;
      logic [FLG_W-1:0] flags;
      logic             ae;
      logic             hit;
      logic             timeout;
      logic [LAT_W-1:0] latency;
   } rec_t;

   function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
      return (v == '1) ? v : v + LAT_W'(1);
   endfunction

endpackage

// File: rtl/ptw_rec_fifo.sv
// Synchronous record FIFO; a push on a full FIFO lands only when a pop frees a slot.
// Read data is forced to zero while empty so the head never shows stale contents.
module ptw_rec_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 74
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // NOTE: the storage array has no reset; only pointers and count are reset, and empty gating hides old data.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ptw_txn_tracker.sv
// Tracks one outstanding PTW request at a time, times its latency, and queues a
// completion (or timeout) record per walk together with hit/miss/drop statistics.
module ptw_txn_tracker
   import ptw_trk_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_ready,
   input  logic             req_valid,
   input  logic [26:0]      req_addr,
   input  logic             resp_valid,
   input  logic             resp_ae,
   input  logic [53:0]      resp_ppn,
   input  logic [7:0]       resp_flags,
   output logic             rec_valid,
   input  logic             rec_ready,
   output logic [REC_W-1:0] rec_data,
   output logic [31:0]      hit_count,
   output logic [31:0]      miss_count,
   output logic [15:0]      drop_count,
   output logic             err_overlap,
   output logic             err_orphan
);

   state_e           state_q;
   logic [VPN_W-1:0] vpn_q;
   logic [LAT_W-1:0] lat_q;
   logic [LAT_W-1:0] lat_inc;
   rec_t             stage_rec_q;
   logic             stage_vld_q;
   logic             fire;
   logic             resp_hit;
   logic             timeout_now;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic             unused_ppn_hi;

   assign fire          = req_valid & req_ready;
   assign resp_hit      = resp_flags[0] & ~resp_ae;
   assign lat_inc       = sat_inc(lat_q);
   assign timeout_now   = (32'(lat_q) + 32'd1) >= 32'(TIMEOUT);
   assign rec_valid     = ~fifo_empty;
   assign pop           = rec_valid & rec_ready;
   assign unused_ppn_hi = ^resp_ppn[53:PPN_W];

   // NOTE: non-blocking assignments throughout so every register sees the pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         vpn_q       <= '0;
         lat_q       <= '0;
         stage_rec_q <= '0;
         stage_vld_q <= 1'b0;
         hit_count   <= '0;
         miss_count  <= '0;
         err_overlap <= 1'b0;
         err_orphan  <= 1'b0;
      end else begin
         stage_vld_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (resp_valid) err_orphan <= 1'b1;
               if (fire) begin
                  state_q <= WAIT;
                  vpn_q   <= req_addr;
                  lat_q   <= '0;
               end
            end
            WAIT: begin
               if (resp_valid) begin
                  stage_vld_q <= 1'b1;
                  stage_rec_q <= '{vpn: vpn_q, ppn: resp_ppn[PPN_W-1:0], flags: resp_flags,
                                   ae: resp_ae, hit: resp_hit, timeout: 1'b0, latency: lat_inc};
                  if (resp_hit) hit_count  <= hit_count + 32'd1;
                  else          miss_count <= miss_count + 32'd1;
                  // A back-to-back request restarts the walk without leaving WAIT.
                  if (fire) begin
                     vpn_q <= req_addr;
                     lat_q <= '0;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  if (fire) err_overlap <= 1'b1;
                  if (timeout_now) begin
                     stage_vld_q <= 1'b1;
                     stage_rec_q <= '{vpn: vpn_q, ppn: '0, flags: '0, ae: 1'b0,
                                      hit: 1'b0, timeout: 1'b1, latency: lat_inc};
                     state_q     <= IDLE;
                  end else begin
                     lat_q <= lat_inc;
                  end
               end
            end
         endcase
      end
   end

   // A staged record is lost only when the FIFO is full and nothing leaves this cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_count <= '0;
      end else if (stage_vld_q && fifo_full && !pop && drop_count != '1) begin
         drop_count <= drop_count + 16'd1;
      end
   end

   ptw_rec_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (stage_vld_q),
      .wr_data (stage_rec_q),
      .pop     (pop),
      .rd_data (rec_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule

// File: tb/tb_ptw_txn_tracker.sv
// Self-checking bench: directed scenarios plus randomized traffic compared each
// cycle against a walk/latency/queue reference model.
module tb_ptw_txn_tracker;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_ready = 1'b0;
   logic        req_valid = 1'b0;
   logic [26:0] req_addr = '0;
   logic        resp_valid = 1'b0;
   logic        resp_ae = 1'b0;
   logic [53:0] resp_ppn = '0;
   logic [7:0]  resp_flags = '0;
   logic        rec_valid;
   logic        rec_ready = 1'b0;
   logic [73:0] rec_data;
   logic [31:0] hit_count;
   logic [31:0] miss_count;
   logic [15:0] drop_count;
   logic        err_overlap;
   logic        err_orphan;

   always #5 clk = ~clk;

   ptw_txn_tracker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_ready   (req_ready),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .resp_valid  (resp_valid),
      .resp_ae     (resp_ae),
      .resp_ppn    (resp_ppn),
      .resp_flags  (resp_flags),
      .rec_valid   (rec_valid),
      .rec_ready   (rec_ready),
      .rec_data    (rec_data),
      .hit_count   (hit_count),
      .miss_count  (miss_count),
      .drop_count  (drop_count),
      .err_overlap (err_overlap),
      .err_orphan  (err_orphan)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: a walk is an active flag plus the edge it started on; latency is edge distance.
   bit          m_active;
   logic [26:0] m_vpn;
   int          m_start;
   int          edge_n = 0;
   logic [73:0] m_fifo[$];
   bit          m_stage_v;
   logic [73:0] m_stage;
   logic [31:0] m_hit;
   logic [31:0] m_miss;
   logic [15:0] m_drop;
   bit          m_ovl;
   bit          m_orph;

   function automatic logic [73:0] mk_rec(input logic [26:0] vpn, input logic [19:0] ppn,
                                          input logic [7:0] fl, input bit ae, input bit hit,
                                          input bit to, input logic [15:0] lat);
      return {vpn, ppn, fl, ae, hit, to, lat};
   endfunction

   function automatic void model_reset();
      m_active  = 1'b0;
      m_vpn     = '0;
      m_start   = 0;
      m_fifo.delete();
      m_stage_v = 1'b0;
      m_stage   = '0;
      m_hit     = '0;
      m_miss    = '0;
      m_drop    = '0;
      m_ovl     = 1'b0;
      m_orph    = 1'b0;
   endfunction

   function automatic void model_edge();
      bit          fire_now;
      bit          pop_now;
      bit          was_full;
      bit          hit;
      int          lat;
      logic [15:0] lat16;
      edge_n++;
      fire_now = req_valid & req_ready;
      pop_now  = (m_fifo.size() != 0) && rec_ready;
      was_full = (m_fifo.size() == DEPTH);
      if (pop_now) void'(m_fifo.pop_front());
      if (m_stage_v) begin
         if (!was_full || pop_now) m_fifo.push_back(m_stage);
         else if (m_drop != 16'hFFFF) m_drop++;
      end
      m_stage_v = 1'b0;
      if (!m_active) begin
         if (resp_valid) m_orph = 1'b1;
         if (fire_now) begin
            m_active = 1'b1;
            m_vpn    = req_addr;
            m_start  = edge_n;
         end
      end else begin
         lat   = edge_n - m_start;
         lat16 = (lat > 65535) ? 16'hFFFF : 16'(lat);
         if (resp_valid) begin
            hit       = resp_flags[0] & ~resp_ae;
            m_stage   = mk_rec(m_vpn, resp_ppn[19:0], resp_flags, resp_ae, hit, 1'b0, lat16);
            m_stage_v = 1'b1;
            if (hit) m_hit++;
            else     m_miss++;
            if (fire_now) begin
               m_vpn   = req_addr;
               m_start = edge_n;
            end else begin
               m_active = 1'b0;
            end
         end else begin
            if (fire_now) m_ovl = 1'b1;
            if (lat >= TIMEOUT) begin
               m_stage   = mk_rec(m_vpn, 20'h0, 8'h0, 1'b0, 1'b0, 1'b1, lat16);
               m_stage_v = 1'b1;
               m_active  = 1'b0;
            end
         end
      end
   endfunction

   task automatic compare_all();
      logic [73:0] head;
      head = (m_fifo.size() != 0) ? m_fifo[0] : 74'h0;
      check("rec_valid",   128'(rec_valid),   128'(m_fifo.size() != 0));
      check("rec_data",    128'(rec_data),    128'(head));
      check("hit_count",   128'(hit_count),   128'(m_hit));
      check("miss_count",  128'(miss_count),  128'(m_miss));
      check("drop_count",  128'(drop_count),  128'(m_drop));
      check("err_overlap", 128'(err_overlap), 128'(m_ovl));
      check("err_orphan",  128'(err_orphan),  128'(m_orph));
   endtask

   // Called at a falling edge; drives one cycle of inputs and checks after the next falling edge.
   task automatic step(input bit rv, input bit rr, input logic [26:0] a, input bit pv,
                       input bit ae, input logic [7:0] fl, input logic [53:0] ppn);
      req_valid  = rv;
      req_ready  = rr;
      req_addr   = a;
      resp_valid = pv;
      resp_ae    = ae;
      resp_flags = fl;
      resp_ppn   = ppn;
      model_edge();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 27'h0, 1'b0, 1'b0, 8'h0, 54'h0);
   endtask

   task automatic do_fire(input logic [26:0] a);
      step(1'b1, 1'b1, a, 1'b0, 1'b0, 8'h0, 54'h0);
   endtask

   task automatic do_resp(input bit ae, input logic [7:0] fl, input logic [53:0] ppn);
      step(1'b0, 1'b1, 27'h0, 1'b1, ae, fl, ppn);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_rec_valid"},   128'(rec_valid),   128'(0));
      check({tag, "_rec_data"},    128'(rec_data),    128'(0));
      check({tag, "_hit_count"},   128'(hit_count),   128'(0));
      check({tag, "_miss_count"},  128'(miss_count),  128'(0));
      check({tag, "_drop_count"},  128'(drop_count),  128'(0));
      check({tag, "_err_overlap"}, 128'(err_overlap), 128'(0));
      check({tag, "_err_orphan"},  128'(err_orphan),  128'(0));
   endtask

   // Asserts reset between clock edges so its asynchronous effect is observed before any edge.
   task automatic do_reset(input string tag);
      req_valid  = 1'b0;
      resp_valid = 1'b0;
      #2 reset = 1'b1;
      #1 model_reset();
      check_reset_state(tag);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      @(negedge clk);
      do_reset("rst");

      // Basic hit: response three cycles after the fire.
      rec_ready = 1'b0;
      do_fire(27'h1234567);
      idle(2);
      do_resp(1'b0, 8'h01, 54'h15555555ABCDE);
      check("hit_not_yet_valid", 128'(rec_valid), 128'(0));
      idle(1);
      check("hit_rec_valid", 128'(rec_valid), 128'(1));
      check("hit_rec_data", 128'(rec_data),
            128'({27'h1234567, 20'hABCDE, 8'h01, 1'b0, 1'b1, 1'b0, 16'd3}));
      check("hit_count_1", 128'(hit_count), 128'(1));
      rec_ready = 1'b1;
      idle(1);
      check("hit_popped", 128'(rec_valid), 128'(0));

      // Misses: invalid PTE, then valid PTE with access exception.
      do_fire(27'h0AAAAAA);
      do_resp(1'b0, 8'h00, 54'h12345);
      idle(1);
      check("miss_v0_hit_bit", 128'(rec_data[17]), 128'(0));
      idle(1);
      check("miss_count_1", 128'(miss_count), 128'(1));
      do_fire(27'h0555555);
      do_resp(1'b1, 8'h01, 54'h54321);
      idle(1);
      check("miss_ae_hit_bit", 128'(rec_data[17]), 128'(0));
      check("miss_ae_bit", 128'(rec_data[18]), 128'(1));
      idle(1);
      check("miss_count_2", 128'(miss_count), 128'(2));
      check("hit_count_still_1", 128'(hit_count), 128'(1));

      // Timeout eight cycles after the fire, then a fresh fire must be accepted from IDLE.
      do_fire(27'h7654321);
      idle(7);
      check("to_not_before", 128'(rec_valid), 128'(0));
      idle(1);
      check("to_staged_only", 128'(rec_valid), 128'(0));
      idle(1);
      check("to_rec_data", 128'(rec_data),
            128'({27'h7654321, 20'h0, 8'h0, 1'b0, 1'b0, 1'b1, 16'd8}));
      check("to_miss_unchanged", 128'(miss_count), 128'(2));
      do_fire(27'h0000011);
      check("to_back_in_idle", 128'(err_overlap), 128'(0));
      do_resp(1'b0, 8'h01, 54'h1);
      idle(2);

      // FIFO overflow: six walks with the consumer stalled.
      rec_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         do_fire(27'h100 + 27'(i));
         do_resp(1'b0, 8'h01, 54'(i));
      end
      idle(2);
      check("ovf_drop_count", 128'(drop_count), 128'(2));
      check("ovf_rec_valid", 128'(rec_valid), 128'(1));
      rec_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain_vpn_%0d", i), 128'(rec_data[73:47]), 128'(27'h100 + 27'(i)));
         idle(1);
      end
      check("drain_empty", 128'(rec_valid), 128'(0));
      check("hit_count_8", 128'(hit_count), 128'(8));

      // Protocol errors leave the counters alone.
      do_resp(1'b0, 8'h01, 54'h0);
      check("orphan_set", 128'(err_orphan), 128'(1));
      check("orphan_hit", 128'(hit_count), 128'(8));
      check("orphan_miss", 128'(miss_count), 128'(2));
      idle(2);
      check("orphan_no_rec", 128'(rec_valid), 128'(0));
      do_fire(27'h200);
      do_fire(27'h201);
      check("overlap_set", 128'(err_overlap), 128'(1));
      check("overlap_hit", 128'(hit_count), 128'(8));
      check("overlap_miss", 128'(miss_count), 128'(2));
      idle(1);
      do_resp(1'b0, 8'h01, 54'h0);
      idle(1);
      check("overlap_vpn_kept", 128'(rec_data[73:47]), 128'(27'h200));
      check("overlap_lat", 128'(rec_data[15:0]), 128'(3));
      idle(1);

      // Reset two cycles into a walk abandons it.
      do_reset("rst2");
      do_fire(27'h300);
      idle(2);
      do_reset("rst_mid");
      do_resp(1'b0, 8'h01, 54'h0);
      check("mid_orphan", 128'(err_orphan), 128'(1));
      idle(3);
      check("mid_no_rec", 128'(rec_valid), 128'(0));
      check("mid_hit", 128'(hit_count), 128'(0));

      // Randomized traffic against the model.
      do_reset("rst3");
      for (int i = 0; i < 600; i++) begin
         rec_ready = ($urandom_range(0, 99) < 50);
         step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 75, 27'($urandom()),
              $urandom_range(0, 99) < 25, $urandom_range(0, 3) == 0, 8'($urandom()),
              {22'($urandom()), 32'($urandom())});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
